// File: rtl/ram_bist_pkg.sv
// Shared types and defaults for the RAM march-test engine and its bench.
package ram_bist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StM0,
    StM1,
    StM2,
    StM3,
    StFlush,
    StDone
  } state_e;

  localparam logic [7:0] PatternDefault = 8'h55;

endpackage

// File: rtl/ram_bist_chk.sv
// Read-data compare: checks each read one cycle after issue, counts mismatches
// (saturating) and captures the first failing address/expected/read word.
module ram_bist_chk #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got
);

  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic [DATA_WIDTH-1:0] pend_exp_q;
  logic                  mismatch;

  assign mismatch = pend_q && (rdata != pend_exp_q);

  // Track the in-flight read and accumulate the error record.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      pend_exp_q  <= '0;
      err_count   <= '0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
    end else begin
      pend_q      <= rd_en;
      pend_addr_q <= rd_addr;
      pend_exp_q  <= rd_exp;
      if (clear) begin
        err_count <= '0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
      end else if (mismatch) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        // A zero count means this is the first mismatch of the run.
        if (err_count == 8'd0) begin
          fail_addr <= pend_addr_q;
          fail_exp  <= pend_exp_q;
          fail_got  <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/ram_bist.sv
// March-style RAM self test: write P up, read P/write ~P up, read ~P/write P
// down, read P up, then one flush cycle for the final compare.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(PatternDefault)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  phase_q, phase_d;  // 0: read slot, 1: write slot (M1/M2)
  logic                  clear;
  logic [DATA_WIDTH-1:0] exp_word;

  // State, address and read/write phase registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
    end
  end

  // Next-state and RAM access decode for each march element.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    phase_d   = phase_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    exp_word  = '0;
    clear     = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StM0;
          addr_d  = '0;
          phase_d = 1'b0;
          clear   = 1'b1;
        end
      end
      StM0: begin
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = PATTERN;
        if (addr_q == LastAddr) begin
          state_d = StM1;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StM1: begin
        mem_addr = addr_q;
        if (!phase_q) begin
          mem_re   = 1'b1;
          exp_word = PATTERN;
          phase_d  = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = ~PATTERN;
          phase_d   = 1'b0;
          if (addr_q == LastAddr) state_d = StM2;
          else                    addr_d  = addr_q + 1'b1;
        end
      end
      StM2: begin
        mem_addr = addr_q;
        if (!phase_q) begin
          mem_re   = 1'b1;
          exp_word = ~PATTERN;
          phase_d  = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = PATTERN;
          phase_d   = 1'b0;
          if (addr_q == '0) state_d = StM3;
          else              addr_d  = addr_q - 1'b1;
        end
      end
      StM3: begin
        mem_re   = 1'b1;
        mem_addr = addr_q;
        exp_word = PATTERN;
        if (addr_q == LastAddr) begin
          state_d = StFlush;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      StFlush: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StM0) || (state_q == StM1) || (state_q == StM2) ||
                (state_q == StM3) || (state_q == StFlush);
  assign done = (state_q == StDone);
  assign pass = done && (err_count == 8'd0);

  ram_bist_chk #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .rd_en    (mem_re),
    .rd_addr  (mem_addr),
    .rd_exp   (exp_word),
    .rdata    (mem_rdata),
    .err_count(err_count),
    .fail_addr(fail_addr),
    .fail_exp (fail_exp),
    .fail_got (fail_got)
  );

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: team RAM model with fault injection, a march-sequence
// model checked every cycle, and directed scenarios with literal expectations.
module tb_ram_bist;
  import ram_bist_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;
  localparam int D  = 8;
  localparam logic [DW-1:0] P = PatternDefault;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_exp, fail_got;
  logic          mem_we, mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  ram_bist dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_got(fail_got), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Team single-port RAM: registered read, one-cycle latency.
  logic [DW-1:0] ram [D];
  logic [DW-1:0] ram_dout;
  logic [AW-1:0] ram_raddr;
  int            fault_mode = 0;  // 0 none, 1 bit0 stuck-1 at addr 5, 2 all reads 0

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) begin
      ram_dout  <= ram[mem_addr];
      ram_raddr <= mem_addr;
    end
  end

  function automatic logic [DW-1:0] faulty(input logic [DW-1:0] v, input int a);
    if (fault_mode == 2) return '0;
    if (fault_mode == 1 && a == 5) return v | 8'h01;
    return v;
  endfunction

  always_comb mem_rdata = faulty(ram_dout, int'(ram_raddr));

  // Expected access sequence of one run; the final entry is the flush cycle.
  typedef struct {
    bit            we;
    bit            re;
    int            addr;
    logic [DW-1:0] data;
  } op_t;
  op_t seq[$];

  function automatic void push_op(input bit we, input bit re, input int a,
                                  input logic [DW-1:0] d);
    op_t o;
    o.we = we; o.re = re; o.addr = a; o.data = d;
    seq.push_back(o);
  endfunction

  function automatic void build_seq();
    seq.delete();
    for (int a = 0; a < D; a++) push_op(1, 0, a, P);
    for (int a = 0; a < D; a++) begin push_op(0, 1, a, P);  push_op(1, 0, a, ~P); end
    for (int a = D - 1; a >= 0; a--) begin push_op(0, 1, a, ~P); push_op(1, 0, a, P); end
    for (int a = 0; a < D; a++) push_op(0, 1, a, P);
    push_op(0, 0, 0, '0);
  endfunction

  int            exp_err, exp_faddr;
  logic [DW-1:0] exp_fexp, exp_fgot;

  // Walk the sequence against an ideal memory seen through the fault.
  function automatic void compute_results();
    logic [DW-1:0] mm [D];
    logic [DW-1:0] got;
    exp_err = 0; exp_faddr = 0; exp_fexp = '0; exp_fgot = '0;
    foreach (seq[i]) begin
      if (seq[i].we) mm[seq[i].addr] = seq[i].data;
      if (seq[i].re) begin
        got = faulty(mm[seq[i].addr], seq[i].addr);
        if (got != seq[i].data) begin
          if (exp_err == 0) begin
            exp_faddr = seq[i].addr; exp_fexp = seq[i].data; exp_fgot = got;
          end
          if (exp_err < 255) exp_err++;
        end
      end
    end
  endfunction

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Model of run progress: active window, index into seq, done flag.
  bit m_active = 0, m_done = 0, seen_reset = 0;
  int m_idx = 0;
  int busy_cycles = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_idx = 0; seen_reset = 1;
      exp_err = 0; exp_faddr = 0; exp_fexp = '0; exp_fgot = '0;
    end else begin
      if (busy) busy_cycles++;
      if (m_active) begin
        m_idx++;
        if (m_idx == seq.size()) begin m_active = 0; m_done = 1; end
      end else if (start) begin
        m_active = 1; m_done = 0; m_idx = 0; busy_cycles = 0;
        compute_results();
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (seen_reset) begin
      op_t op;
      chk("we_re_exclusive", {31'd0, mem_we & mem_re}, 32'd0);
      chk("busy", busy, m_active);
      chk("done", done, m_done);
      if (m_active) begin
        op = seq[m_idx];
        chk("mem_we", mem_we, op.we);
        chk("mem_re", mem_re, op.re);
        if (op.we || op.re) chk("mem_addr", mem_addr, op.addr);
        if (op.we) chk("mem_wdata", mem_wdata, op.data);
        if (m_idx == 0) begin
          chk("cleared_err", err_count, 0);
          chk("cleared_faddr", fail_addr, 0);
          chk("cleared_fexp", fail_exp, 0);
          chk("cleared_fgot", fail_got, 0);
        end
      end else begin
        chk("idle_we", mem_we, 0);
        chk("idle_re", mem_re, 0);
        chk("pass", pass, m_done && exp_err == 0);
        chk("err_count", err_count, exp_err);
        chk("fail_addr", fail_addr, exp_faddr);
        chk("fail_exp", fail_exp, exp_fexp);
        chk("fail_got", fail_got, exp_fgot);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s_timeout: done=%0b after %0d cycles, want 1", name, done, n);
    end
  endtask

  initial begin
    build_seq();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("reset_busy", busy, 0);
    chk("reset_err", err_count, 0);

    // Fault-free run.
    pulse_start();
    wait_done("clean");
    chk("clean_busy_len", busy_cycles, 49);
    chk("clean_pass", pass, 1);
    chk("clean_err", err_count, 0);

    // Bit0 stuck at 1 on reads of address 5: only the ~P read mismatches.
    fault_mode = 1;
    pulse_start();
    wait_done("addr5");
    chk("addr5_pass", pass, 0);
    chk("addr5_err", err_count, 1);
    chk("addr5_faddr", fail_addr, 5);
    chk("addr5_fexp", fail_exp, 8'hAA);
    chk("addr5_fgot", fail_got, 8'hAB);

    // All reads return zero: every one of the 24 reads mismatches.
    fault_mode = 2;
    pulse_start();
    wait_done("zeros");
    chk("zeros_err", err_count, 24);
    chk("zeros_faddr", fail_addr, 0);
    chk("zeros_fexp", fail_exp, 8'h55);
    chk("zeros_fgot", fail_got, 8'h00);

    // Rerun from DONE clears prior results; a start during M1 is ignored.
    fault_mode = 0;
    pulse_start();
    repeat (12) tick();
    pulse_start();
    wait_done("restart");
    chk("restart_busy_len", busy_cycles, 49);
    chk("restart_pass", pass, 1);
    chk("restart_err", err_count, 0);

    // Reset during M2, then a full run.
    pulse_start();
    repeat (30) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_we", mem_we, 0);
    chk("midrst_re", mem_re, 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    wait_done("after_rst");
    chk("after_rst_busy_len", busy_cycles, 49);
    chk("after_rst_pass", pass, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_bist.md
RAM_BIST -- requirements
Module: ram_bist

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-003 SHALL have parameter DEPTH, default 8, number of words tested (addresses 0..DEPTH-1).
REQ-004 SHALL have parameter PATTERN, default 8'h55 (DATA_WIDTH bits), background pattern P; ~P is its bitwise inverse.
REQ-005 SHALL have ports, clock and reset first:
 clk  input  1  single clock, all logic on posedge;
 rst_n  input  1  synchronous active-low reset;
 start  input  1  begin test when idle;
 busy  output  1  test in progress;
 done  output  1  test finished, held until next start;
 pass  output  1  done with zero errors;
 err_count  output  8  mismatches seen, saturating at 255;
 fail_addr  output  ADDR_WIDTH  address of first mismatch;
 fail_exp  output  DATA_WIDTH  expected word at first mismatch;
 fail_got  output  DATA_WIDTH  read word at first mismatch;
 mem_we  output  1  RAM write enable;
 mem_re  output  1  RAM read enable;
 mem_addr  output  ADDR_WIDTH  RAM address;
 mem_wdata  output  DATA_WIDTH  RAM write data;
 mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after mem_re.

Function
REQ-006 SHALL drive the RAM port of the team's single-port RAM: write on posedge when mem_we; read registered on posedge when mem_re, one-cycle latency.
REQ-007 SHALL implement FSM states IDLE, M0, M1, M2, M3, FLUSH, DONE.
REQ-008 IDLE/DONE: start=1 at a posedge SHALL enter M0 next cycle, clear err_count, fail_* and done; start while busy SHALL be ignored.
REQ-009 M0: one write of P per cycle, addresses ascending 0..DEPTH-1 (DEPTH cycles).
REQ-010 M1: per address ascending, read cycle (mem_re, expect P) then write cycle (mem_we, data ~P) (2*DEPTH cycles).
REQ-011 M2: per address descending DEPTH-1..0, read (expect ~P) then write P (2*DEPTH cycles).
REQ-012 M3: one read per cycle ascending, expect P (DEPTH cycles); then FLUSH for one cycle for the last compare; then DONE.
REQ-013 mem_we and mem_re SHALL never be asserted in the same cycle; both 0 in IDLE, FLUSH, DONE.
REQ-014 Every read issued in cycle n SHALL be compared with mem_rdata in cycle n+1 against expected word and address registered in cycle n.
REQ-015 On mismatch err_count SHALL increment (saturate at 255); fail_addr/exp/got SHALL capture only the first mismatch of a run.
REQ-016 busy SHALL be 1 exactly in M0..FLUSH: 6*DEPTH+1 cycles (49 at defaults).
REQ-017 In DONE: done=1, busy=0, pass=(err_count==0); results held until next start.
REQ-018 Address counter SHALL count 0..DEPTH-1 and DEPTH-1..0 without relying on power-of-two wrap.

Reset
REQ-019 rst_n=0 at a posedge SHALL force IDLE and all outputs to 0 (busy, done, pass, err_count, fail_*, mem_*), including mid-test.
REQ-020 Reset SHALL not restore RAM contents; next start SHALL run a full test from M0.

Structure
REQ-021 State encoding and PATTERN default SHALL live in a shared package (ram_bist_pkg) for reuse by the bench.
REQ-022 Single module; the compare/first-fail capture MAY be a sub-module ram_bist_chk.

Verification (bench instantiates the team RAM, defaults)
REQ-023 Fault-free: start pulse -> busy 49 cycles, then done=1, pass=1, err_count=0.
REQ-024 mem_rdata bit0 forced 1 when reading addr 5 -> pass=0, err_count=1, fail_addr=5, fail_exp=8'hAA, fail_got=8'hAB.
REQ-025 mem_rdata forced 8'h00 on all reads -> err_count=24, fail_addr=0, fail_exp=8'h55, fail_got=8'h00.
REQ-026 start re-pulsed during M1 -> ignored, done after original 49 cycles; start in DONE -> clean rerun, prior results cleared.
REQ-027 rst_n low one cycle during M2 -> all outputs 0, IDLE; subsequent start -> full 49-cycle pass.
REQ-028 Every cycle: assert mem_we&mem_re never both 1, and access order matches REQ-009..012.
